minmax_scheduler: RTL and testbench

Sequential min/max tracker that time-shares one WIDTH-bit magnitude comparator between a running-maximum check and a running-minimum check. Samples arrive over a valid/ready stream. After FRAME_LEN samples the block presents the frame maximum, the frame minimum and the frame index of each on a valid/ready result port. It sits between a sample source and any consumer that needs per-frame extremes, replacing two parallel comparators with one scheduled comparator.

---
 rtl/minmax_scheduler.sv | 161 ++++++++++++++++
 tb/tb_minmax_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_scheduler.sv
// minmax_scheduler
//
// Per-frame minimum/maximum tracker built around one shared WIDTH-bit
// unsigned magnitude comparator. Each accepted sample is compared first
// against the running maximum (CMP_MAX) and then against the running
// minimum (CMP_MIN). After FRAME_LEN samples the frame result is held on the
// output port until the consumer takes it.
//
// Handshake rule (both ports): a transfer happens on the rising clk edge
// where valid and ready are both high. Valid, once raised, is not withdrawn
// until that edge. Data is sampled only on the transfer edge.
//
// Optional feature: define MINMAX_EQCNT_EN to add out_eq_cnt, the number of
// samples in the frame equal to the final maximum.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  sample stream handshake, in_data = sample (unsigned)
//   out_valid/ready frame result handshake
//   out_max/out_min frame extremes
//   out_max_idx     index of first occurrence of the maximum
//   out_min_idx     index of first occurrence of the minimum
//   out_eq_cnt      (MINMAX_EQCNT_EN only) samples equal to the maximum
//   dbg_state       current FSM state (ACCEPT=0, CMP_MAX=1, CMP_MIN=2, DONE=3)
module minmax_scheduler #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int IDXW      = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_max_idx,
  output logic [IDXW-1:0]  out_min_idx,
`ifdef MINMAX_EQCNT_EN
  output logic [IDXW:0]    out_eq_cnt,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [IDXW:0] LAST_CNT = (IDXW+1)'(FRAME_LEN - 1);

  state_t           state;
  logic [WIDTH-1:0] sample_r;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] min_r;
  logic [IDXW-1:0]  max_idx_r;
  logic [IDXW-1:0]  min_idx_r;
  logic [IDXW:0]    count_r;   // samples completed in this frame, 0..FRAME_LEN
  logic             first_r;   // next compared sample is the frame's first
`ifdef MINMAX_EQCNT_EN
  logic [IDXW:0]    eq_cnt_r;
`endif

  // The one shared comparator. Operand B follows the state; results are
  // only consumed in CMP_MAX and CMP_MIN.
  logic [WIDTH-1:0] cmp_b;
  logic             a_gt;
  logic             a_eq;
  logic             a_lt;

  always_comb begin
    cmp_b = (state == CMP_MAX) ? max_r : min_r;
    a_gt  = sample_r > cmp_b;
    a_eq  = sample_r == cmp_b;
    a_lt  = !a_gt && !a_eq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sample_r  <= '0;
      max_r     <= '0;
      min_r     <= '0;
      max_idx_r <= '0;
      min_idx_r <= '0;
      count_r   <= '0;
      first_r   <= 1'b1;
`ifdef MINMAX_EQCNT_EN
      eq_cnt_r  <= '0;
`endif
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            sample_r <= in_data;
            in_ready <= 1'b0;
            state    <= CMP_MAX;
          end
        end
        CMP_MAX: begin
          // Strict greater-than: ties keep the earlier index.
          if (first_r || a_gt) begin
            max_r     <= sample_r;
            max_idx_r <= count_r[IDXW-1:0];
`ifdef MINMAX_EQCNT_EN
            eq_cnt_r  <= (IDXW+1)'(1);
          end else if (a_eq) begin
            eq_cnt_r  <= eq_cnt_r + 1'b1;
`endif
          end
          state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (first_r || a_lt) begin
            min_r     <= sample_r;
            min_idx_r <= count_r[IDXW-1:0];
          end
          first_r <= 1'b0;
          count_r <= count_r + 1'b1;
          if (count_r == LAST_CNT) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        DONE: begin
          if (out_ready) begin
            count_r   <= '0;
            first_r   <= 1'b1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCEPT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ACCEPT;
        end
      endcase
    end
  end

  assign out_max     = max_r;
  assign out_min     = min_r;
  assign out_max_idx = max_idx_r;
  assign out_min_idx = min_idx_r;
`ifdef MINMAX_EQCNT_EN
  assign out_eq_cnt  = eq_cnt_r;
`endif
  assign dbg_state   = state;

endmodule

// File: tb/tb_minmax_scheduler.sv
// tb_minmax_scheduler
//
// Self-checking bench for minmax_scheduler with WIDTH=4, FRAME_LEN=4.
// Frames are packed into one vector, sample i at bits [i*WIDTH +: WIDTH].
// A reference model computes each frame's expected result when the frame is
// driven; it is queued and popped when the DUT presents the result.
module tb_minmax_scheduler;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 4;
  localparam int IDXW      = $clog2(FRAME_LEN);
  localparam int FW        = FRAME_LEN * WIDTH;
  localparam int EW        = (IDXW + 1) + 2 * IDXW + 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [IDXW-1:0]  out_max_idx;
  logic [IDXW-1:0]  out_min_idx;
  logic [IDXW:0]    eq_cnt;
  logic [1:0]       dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hs_cyc      = 0;

  logic [EW-1:0] exp_q[$];

  minmax_scheduler #(
    .WIDTH(WIDTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max(out_max),
    .out_min(out_min),
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx),
`ifdef MINMAX_EQCNT_EN
    .out_eq_cnt(eq_cnt),
`endif
    .dbg_state(dbg_state)
  );

`ifndef MINMAX_EQCNT_EN
  assign eq_cnt = '0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_out_min", 32'(out_min), 32'd0);
    check("rst_max_idx", 32'(out_max_idx), 32'd0);
    check("rst_min_idx", 32'(out_min_idx), 32'd0);
    check("rst_eq_cnt", 32'(eq_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [FW-1:0] f);
    logic [WIDTH-1:0] mx, mn, v;
    logic [IDXW-1:0]  mxi, mni;
    logic [IDXW:0]    eq;
    mx = f[WIDTH-1:0];
    mn = mx;
    mxi = '0;
    mni = '0;
    eq = 1;
    for (int i = 1; i < FRAME_LEN; i++) begin
      v = f[i*WIDTH +: WIDTH];
      if (v > mx) begin
        mx = v;
        mxi = IDXW'(i);
        eq = 1;
      end else if (v == mx) begin
        eq = eq + 1'b1;
      end
      if (v < mn) begin
        mn = v;
        mni = IDXW'(i);
      end
    end
`ifndef MINMAX_EQCNT_EN
    eq = '0;
`endif
    return {eq, mxi, mni, mx, mn};
  endfunction

  // ---------------- drivers ----------------
  // Leaves the caller just after the handshake edge (ok=1) or after a
  // bounded wait for in_ready (ok=0, already counted as a failure).
  task automatic send_sample(input logic [WIDTH-1:0] v, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = v;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("hs_timeout", 32'd0, 32'd1);
      ok = 1'b0;
    end else begin
      step();
      ok = 1'b1;
      // in_data is don't-care outside the handshake edge
      in_data = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int gap);
    bit ok;
    int n;
    exp_q.push_back(model(f));
    for (int i = 0; i < FRAME_LEN; i++) begin
      send_sample(f[i*WIDTH +: WIDTH], ok);
      if (!ok) return;
      if (i == 0) hs_cyc = cyc;
      check("busy_in_ready", 32'(in_ready), 32'd0);
      if (gap > 0 && i < FRAME_LEN - 1) begin
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 10) begin
          step();
          n++;
        end
        for (int g = 0; g < gap; g++) begin
          check("gap_in_ready", 32'(in_ready), 32'd1);
          step();
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Waits for the frame result, optionally holds out_ready low for `hold`
  // cycles, then completes the result handshake and checks the bubble.
  task automatic collect(input bit chk_lat, input int hold);
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (!out_valid) begin
      check("out_timeout", 32'd0, 32'd1);
      return;
    end
    // A frame spans 3*FRAME_LEN cycles counting the handshake cycle itself,
    // so out_valid is first seen 3*FRAME_LEN-1 edges after that edge.
    if (chk_lat) check("latency", 32'(cyc - hs_cyc), 32'(3 * FRAME_LEN - 1));
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      got = {eq_cnt, out_max_idx, out_min_idx, out_max, out_min};
      check("hold_outputs", 32'(got), 32'(e));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    check("done_state", 32'(dbg_state), 32'd3);
    check("out_min", 32'(out_min), 32'(e[WIDTH-1:0]));
    check("out_max", 32'(out_max), 32'(e[2*WIDTH-1:WIDTH]));
    check("out_min_idx", 32'(out_min_idx), 32'(e[2*WIDTH+IDXW-1:2*WIDTH]));
    check("out_max_idx", 32'(out_max_idx), 32'(e[2*WIDTH+2*IDXW-1:2*WIDTH+IDXW]));
    check("out_eq_cnt", 32'(eq_cnt), 32'(e[EW-1:2*WIDTH+2*IDXW]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    logic [FW-1:0] f;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    do_reset();

    send_frame(16'h0A35, 0); collect(1'b1, 0);  // 5,3,10,0 back to back
    send_frame(16'h7777, 0); collect(1'b1, 0);  // all equal
    send_frame(16'h0F0F, 0); collect(1'b1, 0);  // 15,0,15,0 ties and bounds
    send_frame(16'h0A35, 2); collect(1'b0, 0);  // same frame with idle gaps

    f = FW'($urandom_range(0, 65535));
    send_frame(f, 0); collect(1'b0, 5);         // consumer stalls 5 cycles
    send_frame(16'h4321, 0); collect(1'b0, 0);  // 1,2,3,4

    // Reset while sample 2 is in CMP_MAX; the partial frame is discarded.
    send_sample(4'd12, ok);
    send_sample(4'd1, ok);
    send_sample(4'd6, ok);
    in_valid = 1'b0;
    check("pre_rst_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_out_max", 32'(out_max), 32'd0);
    check("arst_out_min", 32'(out_min), 32'd0);
    check("arst_max_idx", 32'(out_max_idx), 32'd0);
    check("arst_min_idx", 32'(out_min_idx), 32'd0);
    check("arst_eq_cnt", 32'(eq_cnt), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    send_frame(16'h8989, 0); collect(1'b1, 0);  // 9,8,9,8

    for (int r = 0; r < 6; r++) begin
      f = FW'($urandom_range(0, 65535));
      send_frame(f, $urandom_range(0, 2));
      collect(1'b0, $urandom_range(0, 3));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
